frame_spi_tx: RTL

//  SPI master that serialises one 8-byte colour frame for a downstream RGBW controller's SPI slave.

---
 rtl/frame_spi_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/frame_spi_tx.sv
`default_nettype none
// ============================================================================
// Module : frame_spi_tx
// Brief  : SPI mode-0 master that sends one snapshotted 8-byte RGBW frame,
//          MSB first, with an idle gap between bytes.
// Rev    : 1.0 - initial release
// ============================================================================
module frame_spi_tx #(
   parameter int         CLK_DIV    = 4,
   parameter int         GAP_CYCLES = 4,
   parameter logic [7:0] SYNC_BYTE  = 8'h55
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] lint_in,
   input  logic [7:0] colorIdx_in,
   input  logic [7:0] red_in,
   input  logic [7:0] green_in,
   input  logic [7:0] blue_in,
   input  logic [7:0] white_in,
   input  logic [7:0] mode_in,
   output logic       busy,
   output logic       done,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic       spi_cs_n
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_setup = 3'd1;
   localparam logic [2:0] c_st_shift = 3'd2;
   localparam logic [2:0] c_st_gap   = 3'd3;
   localparam logic [2:0] c_st_hold  = 3'd4;

   localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
   localparam logic [7:0] c_gap_last = 8'(GAP_CYCLES - 1);
   localparam bit         c_has_gap  = (GAP_CYCLES > 0);

   logic [2:0] r_state;
   logic [7:0] r_div_cnt;
   logic [7:0] r_gap_cnt;
   logic [2:0] r_bit_cnt;
   logic [2:0] r_byte_idx;
   logic [7:0] r_frame [0:7];
   logic       r_busy;
   logic       r_sclk;
   logic       r_mosi;
   logic       r_cs_n;

   logic       w_div_end;
   logic [2:0] w_next_idx;
   logic       w_next_bit;
   logic       w_next_msb;

   assign w_div_end  = (r_div_cnt == c_div_last);
   assign w_next_idx = r_byte_idx + 3'd1;
   // Bit that follows the one currently on the wire within the same byte.
   assign w_next_bit = r_frame[r_byte_idx][3'd6 - r_bit_cnt];
   assign w_next_msb = r_frame[w_next_idx][7];

   assign busy     = r_busy;
   assign spi_sclk = r_sclk;
   assign spi_mosi = r_mosi;
   assign spi_cs_n = r_cs_n;
   assign done     = (r_state == c_st_hold) && w_div_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= c_st_idle;
         r_div_cnt  <= '0;
         r_gap_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_byte_idx <= '0;
         r_busy     <= 1'b0;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_cs_n     <= 1'b1;
         for (int i = 0; i < 8; i++) begin
            r_frame[i] <= '0;
         end
      end else begin
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_frame[0] <= SYNC_BYTE;
                  r_frame[1] <= lint_in;
                  r_frame[2] <= colorIdx_in;
                  r_frame[3] <= red_in;
                  r_frame[4] <= green_in;
                  r_frame[5] <= blue_in;
                  r_frame[6] <= white_in;
                  r_frame[7] <= mode_in;
                  r_state    <= c_st_setup;
                  r_cs_n     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_byte_idx <= '0;
                  r_div_cnt  <= '0;
                  r_sclk     <= 1'b0;
                  r_mosi     <= SYNC_BYTE[7];
               end
            end

            c_st_setup: begin
               if (w_div_end) begin
                  r_div_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_mosi    <= r_frame[r_byte_idx][7];
                  r_state   <= c_st_shift;
               end else begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end
            end

            c_st_shift: begin
               if (w_div_end) begin
                  r_div_cnt <= '0;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                  end else begin
                     // Falling edge: the only point where mosi may move.
                     r_sclk <= 1'b0;
                     if (r_bit_cnt != 3'd7) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_mosi    <= w_next_bit;
                     end else if (r_byte_idx == 3'd7) begin
                        r_state <= c_st_hold;
                     end else if (c_has_gap) begin
                        r_gap_cnt <= '0;
                        r_mosi    <= w_next_msb;
                        r_state   <= c_st_gap;
                     end else begin
                        r_byte_idx <= w_next_idx;
                        r_bit_cnt  <= '0;
                        r_mosi     <= w_next_msb;
                     end
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end
            end

            c_st_gap: begin
               if (r_gap_cnt == c_gap_last) begin
                  r_byte_idx <= w_next_idx;
                  r_bit_cnt  <= '0;
                  r_div_cnt  <= '0;
                  r_state    <= c_st_shift;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 8'd1;
               end
            end

            c_st_hold: begin
               if (w_div_end) begin
                  r_div_cnt <= '0;
                  r_cs_n    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_mosi    <= 1'b0;
                  r_state   <= c_st_idle;
               end else begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end
            end

            default: begin
               r_state <= c_st_idle;
               r_cs_n  <= 1'b1;
               r_busy  <= 1'b0;
               r_sclk  <= 1'b0;
               r_mosi  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
